// File: rtl/riscv_dmem_port_pkg.sv
// Shared definitions for the data-memory port: funct3 size codes,
// access-size decoding and the in-flight load metadata record.
package riscv_dmem_port_pkg;

   localparam logic [2:0] MASK_B  = 3'b000;
   localparam logic [2:0] MASK_H  = 3'b001;
   localparam logic [2:0] MASK_W  = 3'b010;
   localparam logic [2:0] MASK_D  = 3'b011;
   localparam logic [2:0] MASK_BU = 3'b100;
   localparam logic [2:0] MASK_HU = 3'b101;
   localparam logic [2:0] MASK_WU = 3'b110;

   // Offset field sized for the widest (64-bit) data path
   localparam int unsigned META_OFF_W = 3;

   typedef struct packed {
      logic                  valid;
      logic [2:0]            size;
      logic [META_OFF_W-1:0] offset;
   } dmem_meta_t;

   // Access size in bytes; 0 marks an encoding that is never legal
   function automatic logic [3:0] size_bytes(input logic [2:0] size);
      case (size)
         MASK_B, MASK_BU:  size_bytes = 4'd1;
         MASK_H, MASK_HU:  size_bytes = 4'd2;
         MASK_W, MASK_WU:  size_bytes = 4'd4;
         MASK_D:           size_bytes = 4'd8;
         default:          size_bytes = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_dmem_port_load_extend.sv
// Load data alignment: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them according to the funct3 size code.
module riscv_dmem_port_load_extend
   import riscv_dmem_port_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] raw_in,
   input  logic [2:0]            size_in,
   input  logic [META_OFF_W-1:0] offset_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] shifted;

   // Byte-lane shift then width-specific extension
   always_comb begin
      shifted = raw_in >> {offset_in, 3'b000};
      case (size_in)
         MASK_B:  data_out = DATA_WIDTH'($signed(shifted[7:0]));
         MASK_BU: data_out = DATA_WIDTH'(shifted[7:0]);
         MASK_H:  data_out = DATA_WIDTH'($signed(shifted[15:0]));
         MASK_HU: data_out = DATA_WIDTH'(shifted[15:0]);
         MASK_W:  data_out = DATA_WIDTH'($signed(shifted[31:0]));
         MASK_WU: data_out = DATA_WIDTH'(shifted[31:0]);
         default: data_out = shifted;
      endcase
   end

endmodule

// File: rtl/riscv_dmem_port.sv
// Data-memory port between the MEM stage and a fixed-latency synchronous
// RAM: lane-aligned stores with byte enables, pipelined load tracking and
// misaligned-access suppression.
module riscv_dmem_port
   import riscv_dmem_port_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    cpu_read_enable_in,
   input  logic                    cpu_write_enable_in,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr_in,
   input  logic [DATA_WIDTH-1:0]   cpu_data_in,
   input  logic [2:0]              cpu_size_in,
   output logic [DATA_WIDTH-1:0]   cpu_data_out,
   output logic                    cpu_data_valid_out,
   output logic                    cpu_misaligned_out,
   output logic [ADDR_WIDTH-1:0]   cpu_fault_addr_out,
   output logic                    busy_out,
   output logic [ADDR_WIDTH-1:0]   mem_addr_out,
   output logic [DATA_WIDTH-1:0]   mem_data_out,
   output logic [DATA_WIDTH/8-1:0] mem_write_enable_out,
   input  logic [DATA_WIDTH-1:0]   mem_data_in
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

   logic [OFF_W-1:0]      offset;
   logic [OFF_W-1:0]      lane_mask;
   logic [3:0]            acc_bytes;
   logic                  size_legal;
   logic                  aligned;
   logic                  misaligned_c;
   logic                  store_ok;
   logic                  load_ok;

   dmem_meta_t            meta_q [MEM_LATENCY];
   dmem_meta_t            tail;
   logic [CNT_W-1:0]      cnt_q;
   logic                  misaligned_q;
   logic [ADDR_WIDTH-1:0] fault_addr_q;
   logic [DATA_WIDTH-1:0] ext_data;

   // Request decode: legality, alignment and which access actually proceeds
   always_comb begin
      offset       = cpu_addr_in[OFF_W-1:0];
      acc_bytes    = size_bytes(cpu_size_in);
      size_legal   = (acc_bytes != 4'd0) && (acc_bytes <= 4'(BYTES)) &&
                     !((DATA_WIDTH == 32) && (cpu_size_in == MASK_WU));
      aligned      = (offset & OFF_W'(acc_bytes - 4'd1)) == '0;
      misaligned_c = (cpu_read_enable_in || cpu_write_enable_in) && !(size_legal && aligned);
      store_ok     = cpu_write_enable_in && !misaligned_c;
      load_ok      = cpu_read_enable_in && !cpu_write_enable_in && !misaligned_c;
   end

   // RAM request: word address, replicated store lanes, byte enables
   always_comb begin
      mem_addr_out         = '0;
      mem_data_out         = '0;
      mem_write_enable_out = '0;
      lane_mask            = '0;
      if (!rst_in) begin
         mem_addr_out = {cpu_addr_in[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
         lane_mask    = size_legal ? OFF_W'(acc_bytes - 4'd1) : '0;
         for (int i = 0; i < int'(BYTES); i++) begin
            mem_data_out[8*i +: 8] = cpu_data_in[8*(i & int'(lane_mask)) +: 8];
         end
         if (store_ok) begin
            mem_write_enable_out = BYTES'(((16'd1 << acc_bytes) - 16'd1) << offset);
         end
      end
   end

   // Load metadata pipeline, one stage per cycle of RAM latency
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            meta_q[i] <= '0;
         end
      end else begin
         meta_q[0] <= '{valid: load_ok, size: cpu_size_in, offset: META_OFF_W'(offset)};
         for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            meta_q[i] <= meta_q[i-1];
         end
      end
   end

   assign tail = meta_q[MEM_LATENCY-1];

   // In-flight load count: up on accepted load, down on returned load
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q <= '0;
      end else if (load_ok && !tail.valid) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else if (!load_ok && tail.valid) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Fault pulse and sticky fault address
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         misaligned_q <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         misaligned_q <= misaligned_c;
         if (misaligned_c) begin
            fault_addr_q <= cpu_addr_in;
         end
      end
   end

   riscv_dmem_port_load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .raw_in    (mem_data_in),
      .size_in   (tail.size),
      .offset_in (tail.offset),
      .data_out  (ext_data)
   );

   assign cpu_data_valid_out = tail.valid;
   assign cpu_data_out       = tail.valid ? ext_data : '0;
   assign cpu_misaligned_out = misaligned_q;
   assign cpu_fault_addr_out = fault_addr_q;
   assign busy_out           = (cnt_q != '0);

endmodule
